// File: rtl/write_arbiter.sv
// rtl/write_arbiter.sv - two-master write-path arbiter with AW/W/B channel sequencing
//
// Purpose:
//   Arbitrates write-address requests from two masters and walks the
//   granted transaction through its AW, W and B phases. GRANT and SLAVE_SEL
//   are latched when a request is accepted from IDLE and stay fixed until
//   the write response handshake returns the FSM to IDLE.
//   Only one transaction is in flight at a time.
//
// Configuration:
//   WR_ROUND_ROBIN_EN - when defined, simultaneous requests are granted to
//   the master that was not served last. When undefined, master 0 always
//   wins a tie.
//
// Ports:
//   i_aclk          clock, all state changes on the rising edge
//   i_aresetn       synchronous active-low reset
//   i_awvalid_m0/1  write-address request from master 0/1
//   i_awaddr_m0/1   write address from master 0/1
//   i_awready       AWREADY of the currently selected slave
//   i_wvalid        W-channel valid of the granted path
//   i_wready        W-channel ready of the granted path
//   i_wlast         W-channel last-beat marker
//   i_bvalid        B-channel valid of the granted path
//   i_bready        B-channel ready of the granted path
//   o_grant         one-hot granted master {M1,M0}, 2'b00 = none
//   o_slave_sel     one-hot target {DEFAULT,S1,S0}, 3'b000 = none
//   o_aw_pass       AW mux enable, high only in state AW
//   o_w_pass        W mux enable, high only in state W
//   o_b_pass        B mux enable, high only in state B
//   o_busy          high whenever the FSM is not IDLE

module write_arbiter (
  input  logic        i_aclk,
  input  logic        i_aresetn,
  input  logic        i_awvalid_m0,
  input  logic        i_awvalid_m1,
  input  logic [31:0] i_awaddr_m0,
  input  logic [31:0] i_awaddr_m1,
  input  logic        i_awready,
  input  logic        i_wvalid,
  input  logic        i_wready,
  input  logic        i_wlast,
  input  logic        i_bvalid,
  input  logic        i_bready,
  output logic [1:0]  o_grant,
  output logic [2:0]  o_slave_sel,
  output logic        o_aw_pass,
  output logic        o_w_pass,
  output logic        o_b_pass,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [1:0]  r_grant;
  logic [2:0]  r_slave_sel;
  // 1 = master 1 was the last one to complete a transaction.
  logic        r_last_served;

  logic        w_any_req;
  logic        w_prefer_m1;
  logic        w_pick_m1;
  logic [15:0] w_pick_addr_hi;
  logic [2:0]  w_pick_sel;
  logic        w_aw_granted;
  logic        w_aw_hs;
  logic        w_w_last_hs;
  logic        w_b_hs;
  logic        w_unused;

  // ------------------------------------------------------------------
  // Arbitration and address decode (only meaningful while IDLE)
  // ------------------------------------------------------------------
  assign w_any_req = i_awvalid_m0 | i_awvalid_m1;

`ifdef WR_ROUND_ROBIN_EN
  // On a tie, favour whichever master did not complete last.
  assign w_prefer_m1 = ~r_last_served;
  assign w_unused    = ^{i_awaddr_m0[15:0], i_awaddr_m1[15:0]};
`else
  // Fixed priority: master 0 wins every tie; last-served history is
  // tracked but has no influence on the decision.
  assign w_prefer_m1 = 1'b0;
  assign w_unused    = ^{i_awaddr_m0[15:0], i_awaddr_m1[15:0], r_last_served};
`endif

  // Master 1 wins when it is the only requester, or on a tie it is preferred.
  assign w_pick_m1 = i_awvalid_m1 & (~i_awvalid_m0 | w_prefer_m1);

  // Only address bits [31:16] take part in the slave decode.
  assign w_pick_addr_hi = w_pick_m1 ? i_awaddr_m1[31:16] : i_awaddr_m0[31:16];

  always_comb begin
    w_pick_sel = 3'b000;
    if (|w_pick_addr_hi[15:1]) begin
      w_pick_sel = 3'b100;
    end else if (w_pick_addr_hi[0]) begin
      w_pick_sel = 3'b010;
    end else begin
      w_pick_sel = 3'b001;
    end
  end

  // ------------------------------------------------------------------
  // Channel handshakes of the granted path
  // ------------------------------------------------------------------
  // The granted master's own AWVALID qualifies AW acceptance; the other
  // master's request is irrelevant until the next IDLE.
  assign w_aw_granted = r_grant[1] ? i_awvalid_m1 : i_awvalid_m0;
  assign w_aw_hs      = w_aw_granted & i_awready;
  assign w_w_last_hs  = i_wvalid & i_wready & i_wlast;
  assign w_b_hs       = i_bvalid & i_bready;

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge i_aclk) begin
    if (!i_aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------
  // Each phase only looks at its own channel, so early W data and a BVALID
  // arriving with the last W beat are simply not observed until their
  // phase is reached.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_any_req)   w_next_state = ST_AW;
      ST_AW:   if (w_aw_hs)     w_next_state = ST_W;
      ST_W:    if (w_w_last_hs) w_next_state = ST_B;
      ST_B:    if (w_b_hs)      w_next_state = ST_IDLE;
      default:                  w_next_state = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Grant / target / history registers
  // ------------------------------------------------------------------
  always_ff @(posedge i_aclk) begin
    if (!i_aresetn) begin
      r_grant       <= 2'b00;
      r_slave_sel   <= 3'b000;
      r_last_served <= 1'b1;
    end else if (r_state == ST_IDLE && w_any_req) begin
      r_grant     <= {w_pick_m1, ~w_pick_m1};
      r_slave_sel <= w_pick_sel;
    end else if (r_state == ST_B && w_b_hs) begin
      r_grant       <= 2'b00;
      r_slave_sel   <= 3'b000;
      r_last_served <= r_grant[1];
    end
  end

  // ------------------------------------------------------------------
  // FSM: outputs
  // ------------------------------------------------------------------
  always_comb begin
    o_aw_pass = 1'b0;
    o_w_pass  = 1'b0;
    o_b_pass  = 1'b0;
    case (r_state)
      ST_AW:   o_aw_pass = 1'b1;
      ST_W:    o_w_pass  = 1'b1;
      ST_B:    o_b_pass  = 1'b1;
      default: ;
    endcase
    o_busy = (r_state != ST_IDLE);
  end

  assign o_grant     = r_grant;
  assign o_slave_sel = r_slave_sel;

endmodule

// File: tb/tb_write_arbiter.sv
// tb/tb_write_arbiter.sv - directed self-checking bench for write_arbiter

module tb_write_arbiter;

  logic        clk;
  logic        resetn;
  logic        awvalid_m0;
  logic        awvalid_m1;
  logic [31:0] awaddr_m0;
  logic [31:0] awaddr_m1;
  logic        awready;
  logic        wvalid;
  logic        wready;
  logic        wlast;
  logic        bvalid;
  logic        bready;
  logic [1:0]  grant;
  logic [2:0]  slave_sel;
  logic        aw_pass;
  logic        w_pass;
  logic        b_pass;
  logic        busy;

  int total;
  int bad;

  write_arbiter dut (
    .i_aclk       (clk),
    .i_aresetn    (resetn),
    .i_awvalid_m0 (awvalid_m0),
    .i_awvalid_m1 (awvalid_m1),
    .i_awaddr_m0  (awaddr_m0),
    .i_awaddr_m1  (awaddr_m1),
    .i_awready    (awready),
    .i_wvalid     (wvalid),
    .i_wready     (wready),
    .i_wlast      (wlast),
    .i_bvalid     (bvalid),
    .i_bready     (bready),
    .o_grant      (grant),
    .o_slave_sel  (slave_sel),
    .o_aw_pass    (aw_pass),
    .o_w_pass     (w_pass),
    .o_b_pass     (b_pass),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".grant"}, {30'd0, grant}, 32'h0);
    check({tag, ".sel"},   {29'd0, slave_sel}, 32'h0);
    check({tag, ".pass"},  {29'd0, aw_pass, w_pass, b_pass}, 32'h0);
    check({tag, ".busy"},  {31'd0, busy}, 32'h0);
  endtask

  // Full transaction from IDLE: request, optional AWVALID drop in AW,
  // early W data that must stall, a burst of 'beats', one B handshake.
  task automatic txn(input string tag, input logic r0, input logic r1,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input logic [1:0] eg, input logic [2:0] es,
                     input int beats, input logic drop_aw);
    awvalid_m0 = r0; awvalid_m1 = r1; awaddr_m0 = a0; awaddr_m1 = a1;
    awready = 1'b0; wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
    bvalid = 1'b0; bready = 1'b0;
    check({tag, ".lat_grant"}, {30'd0, grant}, 32'h0);
    tick();
    check({tag, ".grant"}, {30'd0, grant}, {30'd0, eg});
    check({tag, ".sel"},   {29'd0, slave_sel}, {29'd0, es});
    check({tag, ".aw"},    {29'd0, aw_pass, w_pass, b_pass}, 32'h4);
    if (drop_aw) begin
      awvalid_m0 = 1'b0; awvalid_m1 = 1'b0; awready = 1'b1;
      tick();
      check({tag, ".drop_aw"}, {29'd0, aw_pass, w_pass, b_pass}, 32'h4);
      check({tag, ".drop_grant"}, {30'd0, grant}, {30'd0, eg});
      awvalid_m0 = r0; awvalid_m1 = r1; awready = 1'b0;
    end
    // W data before AW acceptance must not pass.
    wvalid = 1'b1; wready = 1'b1;
    tick();
    check({tag, ".w_stall"}, {29'd0, aw_pass, w_pass, b_pass}, 32'h4);
    awready = 1'b1;
    tick();
    awready = 1'b0; awvalid_m0 = 1'b0; awvalid_m1 = 1'b0;
    for (int i = 0; i < beats; i++) begin
      wlast = (i == beats - 1);
      check({tag, ".w_beat"}, {29'd0, aw_pass, w_pass, b_pass}, 32'h2);
      tick();
    end
    wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
    check({tag, ".b"}, {29'd0, aw_pass, w_pass, b_pass}, 32'h1);
    check({tag, ".b_sel"}, {29'd0, slave_sel}, {29'd0, es});
    bvalid = 1'b1; bready = 1'b1;
    tick();
    bvalid = 1'b0; bready = 1'b0;
    check_idle({tag, ".done"});
  endtask

  logic [1:0] exp_second;

  initial begin
    total = 0; bad = 0;
    resetn = 1'b0; awvalid_m0 = 1'b0; awvalid_m1 = 1'b0;
    awaddr_m0 = 32'h0; awaddr_m1 = 32'h0; awready = 1'b0;
    wvalid = 1'b0; wready = 1'b0; wlast = 1'b0; bvalid = 1'b0; bready = 1'b0;
    tick(); tick();
    check_idle("reset");
    resetn = 1'b1;
    tick();

    // M0 alone, S0, 4-beat burst
    txn("m0_s0", 1'b1, 1'b0, 32'h0000_1000, 32'h0, 2'b01, 3'b001, 4, 1'b0);
    tick();
    // M1 alone, S1, AWVALID dropped in AW keeps the grant
    txn("m1_s1", 1'b0, 1'b1, 32'h0, 32'h0001_0004, 2'b10, 3'b010, 1, 1'b1);
    tick();
    // M0 to DEFAULT region
    txn("m0_def", 1'b1, 1'b0, 32'h0002_0000, 32'h0, 2'b01, 3'b100, 2, 1'b0);

    // Fresh reset so LAST_SERVED=M1, then two back-to-back ties.
    resetn = 1'b0; tick(); resetn = 1'b1; tick();
`ifdef WR_ROUND_ROBIN_EN
    exp_second = 2'b10;
`else
    exp_second = 2'b01;
`endif
    txn("tie1", 1'b1, 1'b1, 32'h0000_1000, 32'h0001_0004, 2'b01, 3'b001, 1, 1'b0);
    txn("tie2", 1'b1, 1'b1, 32'h0000_1000, 32'h0001_0004, exp_second,
        (exp_second == 2'b10) ? 3'b010 : 3'b001, 1, 1'b0);

    // BVALID coincident with WLAST handshake is not consumed.
    awvalid_m0 = 1'b1; awaddr_m0 = 32'h0000_0040; awready = 1'b1;
    tick();                       // -> AW
    tick();                       // -> W
    awvalid_m0 = 1'b0; awready = 1'b0;
    wvalid = 1'b1; wready = 1'b1; wlast = 1'b1; bvalid = 1'b1; bready = 1'b1;
    check("early_b.in_w", {29'd0, aw_pass, w_pass, b_pass}, 32'h2);
    tick();
    wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
    check("early_b.state_b", {29'd0, aw_pass, w_pass, b_pass}, 32'h1);
    check("early_b.busy", {31'd0, busy}, 32'h1);
    tick();
    bvalid = 1'b0; bready = 1'b0;
    check_idle("early_b.done");

    // Reset in the middle of W abandons the transaction.
    awvalid_m1 = 1'b1; awaddr_m1 = 32'h0001_0000; awready = 1'b1;
    tick(); tick();
    awvalid_m1 = 1'b0; awready = 1'b0; wvalid = 1'b1; wready = 1'b1;
    check("rst_w.in_w", {29'd0, aw_pass, w_pass, b_pass}, 32'h2);
    resetn = 1'b0;
    tick();
    wvalid = 1'b0; wready = 1'b0;
    check_idle("rst_w");
    resetn = 1'b1;
    tick();
    check_idle("rst_w.release");
    // First request after release is arbitrated fresh.
    txn("post_rst", 1'b1, 1'b0, 32'h0003_0000, 32'h0, 2'b01, 3'b100, 3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/write_arbiter.md
WRITE_ARBITER -- requirements
Module: write_arbiter

Interface
REQ-001 SHALL provide these ports:
- ACLK  in  1  single clock; all state updates on rising edge.
- ARESETn  in  1  reset; synchronous, active-low.
- AWVALID_M0, AWVALID_M1  in  1  write-address requests, masters 0/1.
- AWADDR_M0, AWADDR_M1  in  32  write addresses, masters 0/1.
- AWREADY  in  1  AWREADY of currently selected slave.
- WVALID, WREADY, WLAST  in  1  W-channel handshake of granted path.
- BVALID, BREADY  in  1  B-channel handshake of granted path.
- GRANT  out  2  one-hot granted master {M1,M0}; 2'b00 = none.
- SLAVE_SEL  out  3  one-hot target {DEFAULT,S1,S0}; 3'b000 = none.
- AW_PASS, W_PASS, B_PASS  out  1  channel-enable strobes for the interconnect muxes.
- BUSY  out  1  high whenever state is not IDLE.

Function
REQ-002 SHALL run a four-state FSM: IDLE, AW, W, B.
REQ-003 SHALL leave IDLE for AW on the first edge where AWVALID_M0 or AWVALID_M1 is high, with one cycle of grant latency.
REQ-004 SHALL register GRANT and SLAVE_SEL on that IDLE->AW edge and hold both constant until the FSM returns to IDLE.
REQ-005 SHALL decode the granted address as follows: ADDR[31:17]!=0 selects DEFAULT; otherwise ADDR[16]=0 selects S0 and ADDR[16]=1 selects S1.
REQ-006 SHALL move AW->W on AWVALID_granted & AWREADY.
REQ-007 SHALL move W->B on WVALID & WREADY & WLAST, so a burst of any length holds the W state.
REQ-008 SHALL move B->IDLE on BVALID & BREADY, then clear GRANT and SLAVE_SEL to zero.
REQ-009 SHALL drive AW_PASS, W_PASS and B_PASS combinationally, high only in states AW, W and B respectively; at most one is high.
REQ-010 SHALL ignore BVALID outside state B, including a BVALID coincident with the WLAST handshake.
REQ-011 SHALL ignore W-channel activity outside state W, so W data arriving before AW acceptance is stalled, not passed.
REQ-012 SHALL keep the grant if the granted master drops AWVALID in state AW, and stay in AW.
REQ-013 SHALL start a new arbitration only from IDLE, giving at least one IDLE cycle between transactions.
REQ-014 SHALL keep a 1-bit LAST_SERVED register, updated on the B->IDLE edge.

Reset
REQ-015 SHALL, on a rising ACLK edge with ARESETn=0, set state IDLE, GRANT=00, SLAVE_SEL=000, all PASS outputs and BUSY low, and LAST_SERVED=M1.
REQ-016 SHALL abandon any in-progress transaction on reset mid-operation; the first request after release is arbitrated fresh.

Configuration
REQ-017 SHALL, with WR_ROUND_ROBIN_EN defined, grant the master other than LAST_SERVED when both request simultaneously in IDLE.
REQ-018 SHALL, without WR_ROUND_ROBIN_EN, always grant M0 on simultaneous requests; LAST_SERVED is then unused.
REQ-019 SHALL be identical in single-requester behaviour in both configurations.

Verification
REQ-020 SHALL pass: M0 requests alone with AWADDR=0x0000_1000 and a 4-beat burst -> GRANT=01, SLAVE_SEL=001, W held for 4 beats, B_PASS for one handshake, then IDLE.
REQ-021 SHALL pass: M1 requests alone with AWADDR=0x0001_0004 -> GRANT=10, SLAVE_SEL=010.
REQ-022 SHALL pass: M0 requests with AWADDR=0x0002_0000 -> SLAVE_SEL=100 (DEFAULT).
REQ-023 SHALL pass: both masters request twice back-to-back -> with macro, grants M0 then M1; without macro, grants M0 then M0.
REQ-024 SHALL pass: BVALID asserted in the same cycle as the WLAST handshake -> not consumed; B_PASS rises next cycle and completes on the following handshake.
REQ-025 SHALL pass: ARESETn low during state W -> next edge gives IDLE, GRANT=00, all PASS outputs low.
